// File: rtl/adder_rca_core.sv
`default_nettype none
// ============================================================================
// Module      : adder_rca_core
// Description : Clocked ripple-carry adder. Registers {carry_out, sum} of
//               x + y + carry_in over w-bit operands. Subtraction is done by
//               the parent presenting ~y with carry_in = 1.
//               Optional macro ADDER_RCA_OVERFLOW_EN adds a registered
//               signed-overflow output (c[w] ^ c[w-1]).
// Revision    : 1.0 - initial release
// ============================================================================
module adder_rca_core #(
    parameter int w = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [w-1:0] x,
    input  logic [w-1:0] y,
    input  logic         carry_in,
    output logic [w-1:0] sum,
    output logic         carry_out
`ifdef ADDER_RCA_OVERFLOW_EN
    ,
    output logic         overflow
`endif
);

    // Carry chain: w_c[0] is carry_in, w_c[i+1] is the carry out of stage i.
    logic [w:0]   w_c;
    logic [w-1:0] w_s;

    assign w_c[0] = carry_in;

    // One full adder per bit; carry ripples strictly from stage i to i+1.
    generate
        for (genvar i = 0; i < w; i++) begin : g_stage
            assign w_s[i]   = x[i] ^ y[i] ^ w_c[i];
            assign w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
        end
    endgenerate

    logic [w-1:0] sum_d;
    logic [w-1:0] sum_q;
    logic         carry_out_d;
    logic         carry_out_q;

    // Next-state values for the result register, taken straight off the chain.
    always_comb begin
        sum_d       = w_s;
        carry_out_d = w_c[w];
    end

    // Result register; reset wins over any operands sampled on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q       <= '0;
            carry_out_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            carry_out_q <= carry_out_d;
        end
    end

    assign sum       = sum_q;
    assign carry_out = carry_out_q;

`ifdef ADDER_RCA_OVERFLOW_EN
    logic overflow_d;
    logic overflow_q;

    // Signed overflow: carry into the MSB differs from carry out of it.
    // For w = 1 the tap w_c[w-1] is carry_in itself.
    always_comb begin
        overflow_d = w_c[w] ^ w_c[w-1];
    end

    // Overflow register, aligned with the sum register.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_adder_rca_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_rca_core
// Description : Scoreboard bench for adder_rca_core (w = 9). Stimulus pushes
//               hand-computed expected results into a queue; a monitor pops
//               one entry per clock edge and compares against the outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_rca_core;

    localparam int c_w = 9;

    logic           clk;
    logic           rst;
    logic [c_w-1:0] x;
    logic [c_w-1:0] y;
    logic           carry_in;
    logic [c_w-1:0] sum;
    logic           carry_out;
`ifdef ADDER_RCA_OVERFLOW_EN
    logic           overflow;
`endif

    adder_rca_core #(.w(c_w)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .y         (y),
        .carry_in  (carry_in),
        .sum       (sum),
        .carry_out (carry_out)
`ifdef ADDER_RCA_OVERFLOW_EN
        ,
        .overflow  (overflow)
`endif
    );

    typedef struct {
        logic [c_w-1:0] e_sum;
        logic           e_co;
        logic           e_ov;
        string          name;
    } exp_t;

    exp_t q_exp[$];
    int   n_checks = 0;
    int   n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one operation at the falling edge and record its expected result.
    task automatic drive(input logic r, input logic [c_w-1:0] a,
                         input logic [c_w-1:0] b, input logic ci,
                         input logic [c_w-1:0] es, input logic eco,
                         input logic eov, input string nm);
        exp_t e;
        @(negedge clk);
        rst      = r;
        x        = a;
        y        = b;
        carry_in = ci;
        e.e_sum  = es;
        e.e_co   = eco;
        e.e_ov   = eov;
        e.name   = nm;
        q_exp.push_back(e);
    endtask

    // Monitor: every edge consumes the operation sampled on that edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                n_checks++;
                if (sum !== e.e_sum) begin
                    n_errors++;
                    $display("FAIL %s sum: got %0d expected %0d", e.name, sum, e.e_sum);
                end
                n_checks++;
                if (carry_out !== e.e_co) begin
                    n_errors++;
                    $display("FAIL %s carry_out: got %0b expected %0b", e.name, carry_out, e.e_co);
                end
`ifdef ADDER_RCA_OVERFLOW_EN
                n_checks++;
                if (overflow !== e.e_ov) begin
                    n_errors++;
                    $display("FAIL %s overflow: got %0b expected %0b", e.name, overflow, e.e_ov);
                end
`endif
            end
        end
    end

    initial begin
        rst      = 1'b1;
        x        = '0;
        y        = '0;
        carry_in = 1'b0;

        // Reset held two cycles with live operands, then released.
        drive(1'b1, 9'd511, 9'd1,   1'b0, 9'd0,   1'b0, 1'b0, "reset0");
        drive(1'b1, 9'd511, 9'd1,   1'b0, 9'd0,   1'b0, 1'b0, "reset1");
        drive(1'b0, 9'd511, 9'd1,   1'b0, 9'd0,   1'b1, 1'b0, "release_wrap");
        // Basic adds.
        drive(1'b0, 9'd1,   9'd1,   1'b0, 9'd2,   1'b0, 1'b0, "add_1_1");
        drive(1'b0, 9'd5,   9'd3,   1'b0, 9'd8,   1'b0, 1'b0, "add_5_3");
        // Alternating bit patterns.
        drive(1'b0, 9'd341, 9'd170, 1'b0, 9'd511, 1'b0, 1'b0, "alt_cin0");
        drive(1'b0, 9'd341, 9'd170, 1'b1, 9'd0,   1'b1, 1'b0, "alt_cin1");
        // Carry-in and wrap.
        drive(1'b0, 9'd5,   9'd3,   1'b1, 9'd9,   1'b0, 1'b0, "cin_5_3");
        drive(1'b0, 9'd511, 9'd1,   1'b1, 9'd1,   1'b1, 1'b0, "cin_wrap");
        drive(1'b0, 9'd0,   9'd1,   1'b1, 9'd2,   1'b0, 1'b0, "cin_0_1");
        // Subtraction as the parent presents it.
        drive(1'b0, 9'd5,   9'd508, 1'b1, 9'd2,   1'b1, 1'b0, "sub_5_3");
        drive(1'b0, 9'd0,   9'd510, 1'b1, 9'd511, 1'b0, 1'b0, "sub_0_1");
        // Signed overflow cases.
        drive(1'b0, 9'd255, 9'd1,   1'b0, 9'd256, 1'b0, 1'b1, "ovf_pos");
        drive(1'b0, 9'd256, 9'd511, 1'b0, 9'd255, 1'b1, 1'b1, "ovf_neg");
        drive(1'b0, 9'd511, 9'd1,   1'b0, 9'd0,   1'b1, 1'b0, "no_ovf");
        drive(1'b0, 9'd100, 9'd200, 1'b0, 9'd300, 1'b0, 1'b1, "ovf_300");
        // Mid-stream reset discards the operation, then normal flow resumes.
        drive(1'b1, 9'd5,   9'd3,   1'b0, 9'd0,   1'b0, 1'b0, "mid_reset");
        drive(1'b0, 9'd7,   9'd9,   1'b0, 9'd16,  1'b0, 1'b0, "after_reset");

        // Let the monitor drain, bounded by a cycle budget.
        for (int i = 0; i < 10 && q_exp.size() > 0; i++) @(negedge clk);
        n_checks++;
        if (q_exp.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending expected 0", q_exp.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
